// File: rtl/screen_sequencer.sv
// Game-flow controller: START -> GAME -> PLAYER_x -> START.
// Screen changes only at the start of vertical blanking.
module screen_sequencer #(
   parameter int unsigned WIN_POINTS      = 10,
   parameter int unsigned WIN_HOLD_FRAMES = 300,
   parameter logic [7:0]  START_KEY       = 8'h5A,
   parameter logic [7:0]  ABORT_KEY       = 8'h76
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] keycode,
   input  logic        vblnk,
   input  logic [4:0]  points_1,
   input  logic [4:0]  points_2,
   output logic [1:0]  screen,
   output logic        game_rst,
   output logic        game_active
);

   typedef enum logic [1:0] {
      START    = 2'd0,
      GAME     = 2'd1,
      PLAYER_1 = 2'd2,
      PLAYER_2 = 2'd3
   } screen_t;

   localparam int HW = $clog2(WIN_HOLD_FRAMES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(WIN_HOLD_FRAMES - 1);
   localparam logic [4:0] WIN = 5'(WIN_POINTS);

   screen_t       state;
   screen_t       nxt;
   logic          vblnk_q;
   logic [15:0]   keycode_q;
   logic          start_req;
   logic          abort_req;
   logic [HW-1:0] hold_cnt;
   logic          frame_tick;
   logic          key_tick;
   logic          chg;

   assign frame_tick = vblnk & ~vblnk_q;
   assign key_tick   = (keycode != keycode_q)
                     & (keycode[15:8] != 8'hF0);
   assign screen     = state;
   assign chg        = (nxt != state);

   always_comb begin
      nxt = state;
      case (state)
         START: begin
            if (frame_tick && start_req) nxt = GAME;
         end
         GAME: begin
            // abort beats a win; player 1 beats player 2 on a tie
            if (frame_tick) begin
               if (abort_req)             nxt = START;
               else if (points_1 >= WIN)  nxt = PLAYER_1;
               else if (points_2 >= WIN)  nxt = PLAYER_2;
            end
         end
         PLAYER_1, PLAYER_2: begin
            if (frame_tick && (start_req || hold_cnt == HOLD_LAST))
               nxt = START;
         end
         default: nxt = START;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= START;
         game_rst    <= 1'b0;
         game_active <= 1'b0;
         vblnk_q     <= 1'b0;
         keycode_q   <= 16'h0000;
         start_req   <= 1'b0;
         abort_req   <= 1'b0;
         hold_cnt    <= '0;
      end else begin
         vblnk_q   <= vblnk;
         keycode_q <= keycode;
         game_rst  <= 1'b0;
         if (chg) begin
            // a key landing on the transition edge is dropped
            state       <= nxt;
            game_rst    <= (nxt == GAME);
            game_active <= (nxt == GAME);
            start_req   <= 1'b0;
            abort_req   <= 1'b0;
            hold_cnt    <= '0;
         end else begin
            if (key_tick && keycode[7:0] == START_KEY)
               start_req <= 1'b1;
            if (key_tick && keycode[7:0] == ABORT_KEY)
               abort_req <= 1'b1;
            if (frame_tick &&
                (state == PLAYER_1 || state == PLAYER_2))
               hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

endmodule
